pong_sfx_event_gen: RTL and testbench
=====================================

// Module: pong_sfx_event_gen
// PURPOSE
//  Producer side of the point/lose sound-event interface: turns one-cycle game strobes into
//  held 2-bit event codes that drive the speaker tone generator.
//  Sits between the ball/paddle collision logic and the sound block.
//  Keeps both player scores and declares game over.
//  All outputs are registered in the clk25 domain.
// PARAMETERS
//  HOLD_FRAMES  6   frame_tick pulses an event code stays asserted (1..15)
//  WIN_SCORE    9   score that ends the game (1..15)
// PORTS
//  clk25      in   1  25 MHz pixel clock, sole clock
//  rst        in   1  synchronous, active-high reset
//  frame_tick in   1  one-cycle pulse per video frame
//  hit_p1     in   1  ball struck left paddle (1-cycle strobe)
//  hit_p2     in   1  ball struck right paddle (1-cycle strobe)
//  miss_p1    in   1  ball passed left edge (1-cycle strobe)
//  miss_p2    in   1  ball passed right edge (1-cycle strobe)
//  new_game   in   1  level/pulse; leaves GAMEOVER, clears scores
//  point      out  2  01 = p1 hit, 10 = p2 hit, 00 = none
//  lose       out  2  01 = p1 missed, 10 = p2 missed, 11 = game over, 00 = none
//  score_p1   out  4  left player score
//  score_p2   out  4  right player score
//  game_over  out  1  high while in GAMEOVER
// BEHAVIOUR
//  Reset (rst high at posedge): every output 0, state IDLE, hold counter 0. Applies mid-event too.
//  FSM states:
//   IDLE: outputs 00.
//   POINT: point holds the code.
//   LOSE: lose holds the code.
//   GAMEOVER: lose=11 and game_over=1.
//  Latency: strobe at edge N -> code visible after edge N+1. Hold counter loads HOLD_FRAMES.
//  Hold: counter decrements on each frame_tick. The state returns to IDLE on the tick that reaches 0.
//  Codes therefore last exactly HOLD_FRAMES ticks.
//  Miss handling:
//   miss_p1 increments score_p2. miss_p2 increments score_p1. Increment happens on the same edge the code loads.
//   If the new score == WIN_SCORE: go to GAMEOVER instead of LOSE.
//   Scores saturate at WIN_SCORE.
//  Priority in one cycle: miss over hit; miss_p1 over miss_p2; hit_p1 over hit_p2. Losing strobes are dropped.
//  Events arriving in POINT/LOSE: a miss always preempts POINT (restart hold). Other events follow the macro below.
//  GAMEOVER: ignores all strobes and frame_tick.
//   new_game -> IDLE, scores 0, next edge.
//   new_game in any other state also clears scores and returns to IDLE.
//  Strobe coincident with the final frame_tick: the strobe wins, a new event loads.
// CONFIGURATION
//  PONG_SFX_RETRIGGER_EN defined:
//   any accepted strobe during POINT/LOSE replaces the code and reloads the hold counter.
//   A hit may not preempt LOSE.
//  Undefined:
//   hits during POINT/LOSE are ignored (no sound change).
//   Misses still update scores and preempt POINT.
//   A miss during LOSE updates the score and keeps the current code/hold.
// STRUCTURE
//  Shared package pong_pkg:
//   EVT_NONE/EVT_P1/EVT_P2/EVT_GAMEOVER 2-bit codes.
//   State encodings ST_IDLE/ST_POINT/ST_LOSE/ST_GAMEOVER.
//   Score width constant SCORE_W=4.
//  Sub-module frame_hold_timer:
//   inputs: load, load value, frame_tick.
//   output: expired pulse.
//  The top level holds the FSM, priority encode and score registers.
// TESTING
//  Use HOLD_FRAMES=4, WIN_SCORE=3, frame_tick every 16 clocks.
//  Reset then idle: point=00, lose=00, scores 0, game_over=0 for 100 cycles.
//  hit_p1 pulse: point=01 after 1 edge, for exactly 4 ticks, then 00. Scores unchanged.
//  miss_p2 x3, spaced 8 ticks: lose=10 twice, score_p1=1,2, then lose=11, game_over=1.
//   Then new_game -> all 0.
//  hit_p2 and miss_p1 same cycle: lose=01, point=00, score_p2=1.
//  Hit during POINT, first code 01, second hit_p2 at tick 2:
//   with macro: point=10 for 4 more ticks;
//   without: point=01 ends on schedule.
//  rst asserted mid-LOSE: all outputs 0 next edge. Next strobe behaves as from IDLE.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared codes, state encodings and helpers for the Pong sound-event producer.
// Used by pong_sfx_event_gen and frame_hold_timer.
package pong_pkg;

    localparam int SCORE_W = 4;
    localparam int HOLD_W  = 4;

    typedef enum logic [1:0] {
        EVT_NONE     = 2'b00,
        EVT_P1       = 2'b01,
        EVT_P2       = 2'b10,
        EVT_GAMEOVER = 2'b11
    } evt_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_POINT    = 2'b01,
        ST_LOSE     = 2'b10,
        ST_GAMEOVER = 2'b11
    } state_e;

    typedef struct packed {
        logic valid;
        logic is_miss;
        evt_e code;
    } strobe_t;

    // Collapse the four strobes into the single winner: misses beat hits, player 1 beats player 2.
    function automatic strobe_t decode_strobes(
        input logic hit_p1,
        input logic hit_p2,
        input logic miss_p1,
        input logic miss_p2
    );
        strobe_t s;
        s.valid   = hit_p1 | hit_p2 | miss_p1 | miss_p2;
        s.is_miss = miss_p1 | miss_p2;
        if (miss_p1) begin
            s.code = EVT_P1;
        end else if (miss_p2) begin
            s.code = EVT_P2;
        end else if (hit_p1) begin
            s.code = EVT_P1;
        end else if (hit_p2) begin
            s.code = EVT_P2;
        end else begin
            s.code = EVT_NONE;
        end
        return s;
    endfunction

    function automatic logic [SCORE_W-1:0] sat_inc(
        input logic [SCORE_W-1:0] score,
        input logic [SCORE_W-1:0] limit
    );
        return (score >= limit) ? limit : score + 1'b1;
    endfunction

endpackage

// File: rtl/frame_hold_timer.sv
// Frame-tick down-counter that times how long an event code stays asserted.
// expired pulses on the frame_tick that takes the count from 1 to 0.
module frame_hold_timer
    import pong_pkg::*;
(
    input  logic              clk25,
    input  logic              rst,
    input  logic              load,
    input  logic [HOLD_W-1:0] load_val,
    input  logic              frame_tick,
    output logic              expired
);

    logic [HOLD_W-1:0] count_q;
    logic [HOLD_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (frame_tick && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Not gated by load: the top decides whether a coincident strobe overrides the expiry.
    assign expired = frame_tick && (count_q == HOLD_W'(1));

    always_ff @(posedge clk25) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pong_sfx_event_gen.sv
// Turns one-cycle game strobes into held point/lose codes, keeps scores and declares game over.
// Define PONG_SFX_RETRIGGER_EN to let accepted strobes replace a code that is still being held.
module pong_sfx_event_gen
    import pong_pkg::*;
#(
    parameter int HOLD_FRAMES = 6,
    parameter int WIN_SCORE   = 9
) (
    input  logic               clk25,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               hit_p1,
    input  logic               hit_p2,
    input  logic               miss_p1,
    input  logic               miss_p2,
    input  logic               new_game,
    output logic [1:0]         point,
    output logic [1:0]         lose,
    output logic [SCORE_W-1:0] score_p1,
    output logic [SCORE_W-1:0] score_p2,
    output logic               game_over
);

    localparam logic [HOLD_W-1:0]  HOLD_LD = HOLD_W'(HOLD_FRAMES);
    localparam logic [SCORE_W-1:0] WIN_LIM = SCORE_W'(WIN_SCORE);

`ifdef PONG_SFX_RETRIGGER_EN
    localparam logic RETRIGGER = 1'b1;
`else
    localparam logic RETRIGGER = 1'b0;
`endif

    state_e             state_q, state_d;
    evt_e               point_q, point_d;
    evt_e               lose_q, lose_d;
    logic [SCORE_W-1:0] score_p1_q, score_p1_d;
    logic [SCORE_W-1:0] score_p2_q, score_p2_d;
    logic               game_over_q, game_over_d;

    logic               tmr_load;
    logic [HOLD_W-1:0]  tmr_val;
    logic               tmr_expired;

    strobe_t            strobe;
    state_e             cur_state;
    logic [SCORE_W-1:0] new_score;
    logic               take_miss;
    logic               take_hit;

    frame_hold_timer u_hold (
        .clk25      (clk25),
        .rst        (rst),
        .load       (tmr_load),
        .load_val   (tmr_val),
        .frame_tick (frame_tick),
        .expired    (tmr_expired)
    );

    always_comb begin
        state_d     = state_q;
        point_d     = point_q;
        lose_d      = lose_q;
        score_p1_d  = score_p1_q;
        score_p2_d  = score_p2_q;
        game_over_d = game_over_q;
        tmr_load    = 1'b0;
        tmr_val     = '0;

        strobe = decode_strobes(hit_p1, hit_p2, miss_p1, miss_p2);

        // A code on its final tick counts as already idle, so a coincident strobe loads fresh.
        cur_state = (tmr_expired && (state_q == ST_POINT || state_q == ST_LOSE)) ? ST_IDLE : state_q;

        new_score = (strobe.code == EVT_P1) ? sat_inc(score_p2_q, WIN_LIM)
                                            : sat_inc(score_p1_q, WIN_LIM);
        take_miss = strobe.is_miss && ((cur_state != ST_LOSE) || RETRIGGER);
        take_hit  = strobe.valid && !strobe.is_miss &&
                    ((cur_state == ST_IDLE) || (RETRIGGER && cur_state == ST_POINT));

        if (new_game) begin
            state_d     = ST_IDLE;
            point_d     = EVT_NONE;
            lose_d      = EVT_NONE;
            score_p1_d  = '0;
            score_p2_d  = '0;
            game_over_d = 1'b0;
            tmr_load    = 1'b1;
        end else if (state_q != ST_GAMEOVER) begin
            if (strobe.is_miss) begin
                if (strobe.code == EVT_P1) begin
                    score_p2_d = new_score;
                end else begin
                    score_p1_d = new_score;
                end
                // Reaching the winning score ends the game even while a LOSE code is being held.
                if (new_score == WIN_LIM) begin
                    state_d     = ST_GAMEOVER;
                    point_d     = EVT_NONE;
                    lose_d      = EVT_GAMEOVER;
                    game_over_d = 1'b1;
                    tmr_load    = 1'b1;
                end else if (take_miss) begin
                    state_d  = ST_LOSE;
                    point_d  = EVT_NONE;
                    lose_d   = strobe.code;
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LD;
                end
            end else if (take_hit) begin
                state_d  = ST_POINT;
                point_d  = strobe.code;
                lose_d   = EVT_NONE;
                tmr_load = 1'b1;
                tmr_val  = HOLD_LD;
            end else if (cur_state == ST_IDLE) begin
                state_d = ST_IDLE;
                point_d = EVT_NONE;
                lose_d  = EVT_NONE;
            end
        end
    end

    always_ff @(posedge clk25) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            point_q     <= EVT_NONE;
            lose_q      <= EVT_NONE;
            score_p1_q  <= '0;
            score_p2_q  <= '0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            point_q     <= point_d;
            lose_q      <= lose_d;
            score_p1_q  <= score_p1_d;
            score_p2_q  <= score_p2_d;
            game_over_q <= game_over_d;
        end
    end

    assign point     = point_q;
    assign lose      = lose_q;
    assign score_p1  = score_p1_q;
    assign score_p2  = score_p2_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_pong_sfx_event_gen.sv
// Self-checking bench for pong_sfx_event_gen with HOLD_FRAMES=4, WIN_SCORE=3, frame_tick every 16 clocks.
// Expectations follow PONG_SFX_RETRIGGER_EN when the bench is built with it defined.
module tb_pong_sfx_event_gen;

    localparam int HOLD = 4;
    localparam int WIN  = 3;
    localparam int TICK_PERIOD = 16;

`ifdef PONG_SFX_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic       clk25 = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       hit_p1 = 1'b0;
    logic       hit_p2 = 1'b0;
    logic       miss_p1 = 1'b0;
    logic       miss_p2 = 1'b0;
    logic       new_game = 1'b0;
    logic [1:0] point;
    logic [1:0] lose;
    logic [3:0] score_p1;
    logic [3:0] score_p2;
    logic       game_over;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit tick_seen = 1'b0;

    // Reference model: what the speaker should hear, in ticks remaining and plain scores.
    logic [1:0] m_point = 2'b00;
    logic [1:0] m_lose = 2'b00;
    int         m_s1 = 0;
    int         m_s2 = 0;
    bit         m_go = 1'b0;
    int         m_rem = 0;

    pong_sfx_event_gen #(.HOLD_FRAMES(HOLD), .WIN_SCORE(WIN)) dut (
        .clk25      (clk25),
        .rst        (rst),
        .frame_tick (frame_tick),
        .hit_p1     (hit_p1),
        .hit_p2     (hit_p2),
        .miss_p1    (miss_p1),
        .miss_p2    (miss_p2),
        .new_game   (new_game),
        .point      (point),
        .lose       (lose),
        .score_p1   (score_p1),
        .score_p2   (score_p2),
        .game_over  (game_over)
    );

    always #20 clk25 = ~clk25;

    task automatic model_step(input bit t, input bit hp1, input bit hp2, input bit mp1,
                              input bit mp2, input bit ng, input bit rs);
        bit ending;
        bit busy;
        bit loaded;
        int ns;
        loaded = 1'b0;
        if (rs || ng) begin
            m_point = 2'b00; m_lose = 2'b00; m_go = 1'b0; m_rem = 0; m_s1 = 0; m_s2 = 0;
        end else if (!m_go) begin
            ending = t && (m_rem == 1);
            busy = (m_rem > 0) && !ending;
            if (mp1 || mp2) begin
                if (mp1) begin
                    if (m_s2 < WIN) m_s2++;
                    ns = m_s2;
                end else begin
                    if (m_s1 < WIN) m_s1++;
                    ns = m_s1;
                end
                if (ns == WIN) begin
                    m_go = 1'b1; m_lose = 2'b11; m_point = 2'b00; m_rem = 0; loaded = 1'b1;
                end else if (!busy || m_point != 2'b00 || RETRIG) begin
                    m_lose = mp1 ? 2'b01 : 2'b10; m_point = 2'b00; m_rem = HOLD; loaded = 1'b1;
                end
            end else if (hp1 || hp2) begin
                if (!busy || (RETRIG && m_point != 2'b00)) begin
                    m_point = hp1 ? 2'b01 : 2'b10; m_lose = 2'b00; m_rem = HOLD; loaded = 1'b1;
                end
            end
            if (!loaded && t && m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_point = 2'b00; m_lose = 2'b00;
                end
            end
        end
    endtask

    task automatic step(input bit hp1, input bit hp2, input bit mp1, input bit mp2,
                        input bit ng, input bit rs);
        @(negedge clk25);
        frame_tick = ((cyc % TICK_PERIOD) == TICK_PERIOD - 1);
        hit_p1 = hp1; hit_p2 = hp2; miss_p1 = mp1; miss_p2 = mp2; new_game = ng; rst = rs;
        @(posedge clk25);
        tick_seen = frame_tick;
        model_step(frame_tick, hp1, hp2, mp1, mp2, ng, rs);
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 100; i++) begin
            step(0, 0, 0, 0, 0, 0);
            checks++;
            if ({point, lose, score_p1, score_p2, game_over} !== 15'd0) begin
                errors++;
                $display("[TB] FAIL reset_idle cyc=%0d got p=%b l=%b s1=%0d s2=%0d go=%b want all 0",
                         cyc, point, lose, score_p1, score_p2, game_over);
            end
        end
    endtask

    task automatic test_hit_hold();
        int ticks = 0;
        step(1, 0, 0, 0, 0, 0);
        checks++;
        if (point !== 2'b01 || lose !== 2'b00) begin
            errors++;
            $display("[TB] FAIL hit_latency got p=%b l=%b want p=01 l=00", point, lose);
        end
        for (int i = 0; i < 200 && ticks < HOLD; i++) begin
            step(0, 0, 0, 0, 0, 0);
            if (tick_seen) ticks++;
            checks++;
            if (point !== ((ticks < HOLD) ? 2'b01 : 2'b00) || score_p1 !== 4'd0 || score_p2 !== 4'd0) begin
                errors++;
                $display("[TB] FAIL hit_hold ticks=%0d got p=%b s1=%0d s2=%0d want p=%b scores 0",
                         ticks, point, score_p1, score_p2, (ticks < HOLD) ? 2'b01 : 2'b00);
            end
        end
        checks++;
        if (ticks != HOLD) begin
            errors++;
            $display("[TB] FAIL hit_hold_timeout got %0d ticks want %0d", ticks, HOLD);
        end
    endtask

    task automatic test_miss_gameover();
        for (int k = 1; k <= 3; k++) begin
            step(0, 0, 0, 1, 0, 0);
            checks++;
            if (lose !== ((k < 3) ? 2'b10 : 2'b11) || score_p1 !== 4'(k) || game_over !== (k == 3)) begin
                errors++;
                $display("[TB] FAIL miss_p2_%0d got l=%b s1=%0d go=%b want l=%b s1=%0d go=%b",
                         k, lose, score_p1, game_over, (k < 3) ? 2'b10 : 2'b11, k, k == 3);
            end
            for (int i = 0; i < 8 * TICK_PERIOD - 1; i++) begin
                step(0, 0, 0, 0, 0, 0);
                checks++;
                if ({point, lose, score_p1, score_p2, game_over} !==
                    {m_point, m_lose, 4'(m_s1), 4'(m_s2), m_go}) begin
                    errors++;
                    $display("[TB] FAIL miss_run cyc=%0d got %b/%b/%0d/%0d/%b want %b/%b/%0d/%0d/%b",
                             cyc, point, lose, score_p1, score_p2, game_over,
                             m_point, m_lose, m_s1, m_s2, m_go);
                end
            end
        end
        step(1, 0, 1, 0, 0, 0);
        checks++;
        if (lose !== 2'b11 || game_over !== 1'b1 || score_p2 !== 4'd0 || point !== 2'b00) begin
            errors++;
            $display("[TB] FAIL gameover_ignores got l=%b go=%b s2=%0d p=%b want 11/1/0/00",
                     lose, game_over, score_p2, point);
        end
        step(0, 0, 0, 0, 1, 0);
        checks++;
        if ({point, lose, score_p1, score_p2, game_over} !== 15'd0) begin
            errors++;
            $display("[TB] FAIL new_game got p=%b l=%b s1=%0d s2=%0d go=%b want all 0",
                     point, lose, score_p1, score_p2, game_over);
        end
    endtask

    task automatic test_same_cycle();
        step(0, 1, 1, 0, 0, 0);
        checks++;
        if (lose !== 2'b01 || point !== 2'b00 || score_p2 !== 4'd1 || score_p1 !== 4'd0) begin
            errors++;
            $display("[TB] FAIL hit_vs_miss got l=%b p=%b s2=%0d s1=%0d want 01/00/1/0",
                     lose, point, score_p2, score_p1);
        end
        for (int i = 0; i < 80; i++) begin
            step(0, 0, 0, 0, 0, 0);
            checks++;
            if ({point, lose, score_p1, score_p2, game_over} !==
                {m_point, m_lose, 4'(m_s1), 4'(m_s2), m_go}) begin
                errors++;
                $display("[TB] FAIL same_cycle_run cyc=%0d got %b/%b/%0d/%0d/%b want %b/%b/%0d/%0d/%b",
                         cyc, point, lose, score_p1, score_p2, game_over,
                         m_point, m_lose, m_s1, m_s2, m_go);
            end
        end
        step(0, 0, 0, 0, 1, 0);
    endtask

    task automatic test_back_to_back();
        int ticks = 0;
        int t2 = 0;
        logic [1:0] want;
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 100 && ticks < 2; i++) begin
            step(0, 0, 0, 0, 0, 0);
            if (tick_seen) ticks++;
        end
        step(0, 1, 0, 0, 0, 0);
        checks++;
        if (point !== (RETRIG ? 2'b10 : 2'b01)) begin
            errors++;
            $display("[TB] FAIL retrigger_load got p=%b want %b", point, RETRIG ? 2'b10 : 2'b01);
        end
        for (int i = 0; i < 200 && t2 < HOLD; i++) begin
            step(0, 0, 0, 0, 0, 0);
            if (tick_seen) t2++;
            want = RETRIG ? ((t2 < HOLD) ? 2'b10 : 2'b00) : ((t2 < HOLD - 2) ? 2'b01 : 2'b00);
            checks++;
            if (point !== want || point !== m_point) begin
                errors++;
                $display("[TB] FAIL retrigger_hold t2=%0d got p=%b want %b model %b", t2, point, want, m_point);
            end
        end
    endtask

    task automatic test_reset_mid_lose();
        step(0, 0, 1, 0, 0, 0);
        checks++;
        if (lose !== 2'b01 || score_p2 !== 4'd1) begin
            errors++;
            $display("[TB] FAIL lose_load got l=%b s2=%0d want 01/1", lose, score_p2);
        end
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        checks++;
        if ({point, lose, score_p1, score_p2, game_over} !== 15'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid_lose got p=%b l=%b s1=%0d s2=%0d go=%b want all 0",
                     point, lose, score_p1, score_p2, game_over);
        end
        step(1, 0, 0, 0, 0, 0);
        checks++;
        if (point !== 2'b01 || lose !== 2'b00) begin
            errors++;
            $display("[TB] FAIL after_reset_hit got p=%b l=%b want 01/00", point, lose);
        end
    endtask

    task automatic test_random();
        bit hp1, hp2, mp1, mp2, ng, rs;
        for (int i = 0; i < 3000; i++) begin
            hp1 = ($urandom_range(0, 19) == 0);
            hp2 = ($urandom_range(0, 19) == 0);
            mp1 = ($urandom_range(0, 39) == 0);
            mp2 = ($urandom_range(0, 39) == 0);
            ng  = ($urandom_range(0, 299) == 0);
            rs  = ($urandom_range(0, 999) == 0);
            step(hp1, hp2, mp1, mp2, ng, rs);
            checks++;
            if ({point, lose, score_p1, score_p2, game_over} !==
                {m_point, m_lose, 4'(m_s1), 4'(m_s2), m_go}) begin
                errors++;
                $display("[TB] FAIL random cyc=%0d got %b/%b/%0d/%0d/%b want %b/%b/%0d/%0d/%b",
                         cyc, point, lose, score_p1, score_p2, game_over,
                         m_point, m_lose, m_s1, m_s2, m_go);
            end
        end
    endtask

    initial begin
        test_reset();
        test_hit_hold();
        test_miss_gameover();
        test_same_cycle();
        test_back_to_back();
        test_reset_mid_lose();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
